// File: rtl/arm_mul_pkg.sv
// Shared definitions for the iterative multiply unit: FSM state encoding and
// the iteration geometry derived from operand width and bits retired per cycle.
package arm_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MUL_WIDTH   = 32;
    localparam int MUL_BITS_PC = 2;
    localparam int ITER        = MUL_WIDTH / MUL_BITS_PC;
    localparam int CNT_W       = $clog2(ITER);

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PC step: adds mcand * bits into the running product.
// The multiplicand arrives already shifted to the weight of the current digit.
module mul_step
    import arm_mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH,
    parameter int BITS_PC = MUL_BITS_PC
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [BITS_PC-1:0] bits,
    output logic [2*WIDTH-1:0] sum
);

    // Accumulate one shifted copy of the multiplicand per set multiplier bit
    always_comb begin
        sum = prod;
        for (int k = 0; k < BITS_PC; k++) begin
            if (bits[k]) begin
                sum = sum + (mcand << k);
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiply unit (MUL/MLA, optionally UMULL/SMULL).
// Optional feature macro: MUL_LONG_EN enables long_op/signed_op, the FIX
// state (sign correction of signed long products) and the 64-bit flags.
//
// Handshake: start is sampled only in IDLE; once accepted, the operands are
// latched and later input changes have no effect. busy is high while the
// product is being formed (RUN/FIX); done pulses for one cycle when the
// results and flags are updated, and those hold until the next done.
// start seen while busy or in DONE is dropped, never queued.
module mul_unit
    import arm_mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH,
    parameter int BITS_PC = MUL_BITS_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             accumulate,
    input  logic             long_op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic [1:0]       dbg_state
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   step_sum;
    logic                 long_eff;
    logic                 sgn_eff;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

`ifdef MUL_LONG_EN
    logic                 long_q;
    logic                 sgn_q;
    logic                 neg_q;

    assign long_eff = long_op;
    assign sgn_eff  = long_op & signed_op;
`else
    logic                 unused_long;

    assign long_eff    = 1'b0;
    assign sgn_eff     = 1'b0;
    assign unused_long = ^{long_op, signed_op};
    assign result_hi   = '0;
`endif

    // Signed long operands are multiplied as magnitudes; the sign is restored in FIX
    assign a_mag = (sgn_eff && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn_eff && b[WIDTH-1]) ? -b : b;

    assign dbg_state = state;

    mul_step #(
        .WIDTH  (WIDTH),
        .BITS_PC(BITS_PC)
    ) u_step (
        .prod (prod),
        .mcand(mcand),
        .bits (mplier[BITS_PC-1:0]),
        .sum  (step_sum)
    );

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
`ifdef MUL_LONG_EN
            result_hi <= '0;
            long_q    <= 1'b0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        prod   <= (accumulate && !long_eff) ? {{WIDTH{1'b0}}, acc} : '0;
                        cnt    <= CNT_W'(ITER - 1);
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef MUL_LONG_EN
                        long_q <= long_eff;
                        sgn_q  <= sgn_eff;
                        neg_q  <= sgn_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    end
                end
                RUN: begin
                    prod   <= step_sum;
                    mcand  <= mcand << BITS_PC;
                    mplier <= mplier >> BITS_PC;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef MUL_LONG_EN
                        if (sgn_q) begin
                            state <= FIX;
                        end else begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
`else
                        busy  <= 1'b0;
                        state <= DONE;
`endif
                    end
                end
`ifdef MUL_LONG_EN
                FIX: begin
                    if (neg_q) begin
                        prod <= -prod;
                    end
                    busy  <= 1'b0;
                    state <= DONE;
                end
`endif
                DONE: begin
                    done      <= 1'b1;
                    result_lo <= prod[WIDTH-1:0];
`ifdef MUL_LONG_EN
                    result_hi <= long_q ? prod[2*WIDTH-1:WIDTH] : '0;
                    flag_n    <= long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
                    flag_z    <= long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
`else
                    flag_n    <= prod[WIDTH-1];
                    flag_z    <= (prod[WIDTH-1:0] == '0);
`endif
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed cases plus randomized operations, with a
// scoreboard queue filled at issue time and drained by a done-driven monitor.
module tb_mul_unit;

    localparam int W    = 32;
    localparam int NITR = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          accumulate;
    logic          long_op;
    logic          signed_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  acc;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic          flag_n;
    logic          flag_z;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // expected {hi, lo, n, z}
    logic [65:0]   exp_q[$];
    logic [65:0]   last_out;

    mul_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .accumulate(accumulate),
        .long_op   (long_op),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit long_honoured(input logic lng);
`ifdef MUL_LONG_EN
        return lng;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain arithmetic on the architectural meaning of each op
    function automatic logic [65:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [31:0] macc, input logic maccum,
                                          input logic mlong, input logic msgn);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        bit          lng;
        lng = long_honoured(mlong);
        if (lng && msgn) begin
            sa = $signed(ma);
            sb = $signed(mb);
            p  = sa * sb;
            return {p[63:32], p[31:0], p[63], p == 64'd0};
        end else if (lng) begin
            p = {32'd0, ma} * {32'd0, mb};
            return {p[63:32], p[31:0], p[63], p == 64'd0};
        end else begin
            p[31:0]  = ma * mb + (maccum ? macc : 32'd0);
            p[63:32] = 32'd0;
            return {32'd0, p[31:0], p[31], p[31:0] == 32'd0};
        end
    endfunction

    // Monitor: pop on done, otherwise results must hold their last value
    always @(negedge clk) begin
        if (!reset) begin
            last_out = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {result_hi, result_lo, flag_n, flag_z}, 66'd0);
                errors += (checks > 0 && {result_hi, result_lo, flag_n, flag_z} === 66'd0) ? 1 : 0;
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                chk("result_hi", {34'd0, result_hi}, {34'd0, e[65:34]});
                chk("result_lo", {34'd0, result_lo}, {34'd0, e[33:2]});
                chk("flag_n", {65'd0, flag_n}, {65'd0, e[1]});
                chk("flag_z", {65'd0, flag_z}, {65'd0, e[0]});
            end
            last_out = {result_hi, result_lo, flag_n, flag_z};
        end else begin
            chk("hold", {result_hi, result_lo, flag_n, flag_z}, last_out);
        end
    end

    // Driver: issue one operation, scramble inputs while it runs, time it
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tacc,
                          input logic tacc_en, input logic tlong, input logic tsgn,
                          input bit pulse_extra);
        int lat;
        int busy_cnt;
        int exp_lat;
        bit extra;
        extra   = long_honoured(tlong) && tsgn;
        exp_lat = NITR + 1 + (extra ? 1 : 0);
        @(negedge clk);
        a = ta; b = tb_v; acc = tacc;
        accumulate = tacc_en; long_op = tlong; signed_op = tsgn;
        exp_q.push_back(model(ta, tb_v, tacc, tacc_en, tlong, tsgn));
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            a = $urandom; b = $urandom; acc = $urandom;
            @(negedge clk);
            lat++;
            start = pulse_extra && (lat == 5 || lat == exp_lat - 1);
        end
        start = 1'b0;
        if (!done) begin
            $display("FAIL timeout: no done after %0d cycles, expected %0d", lat, exp_lat);
            errors++;
            exp_q.delete();
        end
        chk("latency", 66'(lat), 66'(exp_lat));
        chk("busy_cycles", 66'(busy_cnt), 66'(exp_lat - 1));
        @(negedge clk);
        chk("idle_after", {63'd0, busy, dbg_state}, 66'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; accumulate = 1'b0; long_op = 1'b0; signed_op = 1'b0;
        a = '0; b = '0; acc = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {result_hi, result_lo, flag_n, flag_z}, 66'd0);
        chk("reset_ctrl", {63'd0, busy, done, dbg_state}, 66'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(32'd0, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 32'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        a = 32'd5; b = 32'd9; accumulate = 1'b0; long_op = 1'b0; signed_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrun_reset_outputs", {result_hi, result_lo, flag_n, flag_z}, 66'd0);
        chk("midrun_reset_ctrl", {63'd0, busy, done, dbg_state}, 66'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        run_op(32'd123, 32'd456, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 10; i++) begin
            run_op(32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'hFFFF_FFF0,
                   1'b1, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 66'(exp_q.size()), 66'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
